// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package data_mem_responder_pkg;

  // Responder FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_t;

  // Width of the access-latency counter (WAIT_CYCLES is limited to 0..15).
  localparam int WAIT_W = 4;

  // Error counter width and its saturation value.
  localparam int ERR_COUNT_W = 8;
  localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = 8'hFF;

  // Saturating increment for the error counter.
  function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
    return (v == ERR_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array_be.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Each byte lane is its own array so that byte
// enables map directly onto independent RAM write strobes. No reset.
module data_mem_responder_mem_array_be
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [DATA_W/8-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
      logic [7:0] lane [DEPTH];
      logic [7:0] lane_q;

      // Byte-lane access: optional write and read-first registered read.
      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) begin
            lane[addr] <= wdata[gi*8 +: 8];
          end
          lane_q <= lane[addr];
        end
      end

      assign rdata[gi*8 +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the processor's data-memory request interface. Accepts one
// load/store at a time, waits WAIT_CYCLES, performs the access against a
// byte-enabled word RAM and holds the response until it is consumed.
// Misaligned and out-of-range accesses are reported instead of touching memory.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_SIZE    = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [MEM_WIDTH-1:0]    req_wdata,
  input  logic [MEM_WIDTH/8-1:0]  req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [MEM_WIDTH-1:0]    resp_rdata,
  output logic                    resp_err,
  output logic [7:0]              err_count
);

  localparam int WORD_BYTES = MEM_WIDTH / 8;
  localparam int IDX_W      = $clog2(MEM_SIZE);
  // One past the highest legal byte address, one bit wider than the bus.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE) << 2;

  dmr_state_t              state, state_next;
  logic [WAIT_W-1:0]       wait_cnt, wait_cnt_next;
  logic                    req_ready_next;

  // Request captured on the accept edge.
  logic                    lat_write, lat_write_next;
  logic [ADDR_WIDTH-1:0]   lat_addr, lat_addr_next;
  logic [MEM_WIDTH-1:0]    lat_wdata, lat_wdata_next;
  logic [WORD_BYTES-1:0]   lat_be, lat_be_next;

  // Response state.
  logic                    resp_valid_next;
  logic                    resp_err_next;
  logic                    rd_sel, rd_sel_next;
  logic [7:0]              err_count_next;

  // RAM interface.
  logic                    mem_en;
  logic [WORD_BYTES-1:0]   mem_we;
  logic [MEM_WIDTH-1:0]    mem_q;

  // Address checks on the captured request.
  logic                    acc_misaligned;
  logic                    acc_oor;
  logic                    acc_err;

  assign acc_misaligned = (lat_addr[1:0] != 2'b00);
  assign acc_oor        = ({1'b0, lat_addr} >= ADDR_LIMIT);
  assign acc_err        = acc_misaligned | acc_oor;

  // Load data is only exposed for a successful load; the RAM output register
  // holds its value for the whole response because the RAM is only enabled
  // on the response entry edge.
  assign resp_rdata = rd_sel ? mem_q : '0;

  data_mem_responder_mem_array_be #(
    .DATA_W (MEM_WIDTH),
    .DEPTH  (MEM_SIZE)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (lat_addr[IDX_W+1:2]),
    .wdata (lat_wdata),
    .rdata (mem_q)
  );

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= DMR_IDLE;
      wait_cnt   <= '0;
      req_ready  <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_sel     <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_cnt_next;
      req_ready  <= req_ready_next;
      lat_write  <= lat_write_next;
      lat_addr   <= lat_addr_next;
      lat_wdata  <= lat_wdata_next;
      lat_be     <= lat_be_next;
      resp_valid <= resp_valid_next;
      resp_err   <= resp_err_next;
      rd_sel     <= rd_sel_next;
      err_count  <= err_count_next;
    end
  end

  // Next-state logic, RAM strobes and response updates.
  always_comb begin
    state_next      = state;
    wait_cnt_next   = wait_cnt;
    lat_write_next  = lat_write;
    lat_addr_next   = lat_addr;
    lat_wdata_next  = lat_wdata;
    lat_be_next     = lat_be;
    resp_valid_next = resp_valid;
    resp_err_next   = resp_err;
    rd_sel_next     = rd_sel;
    err_count_next  = err_count;
    mem_en          = 1'b0;
    mem_we          = '0;

    case (state)
      DMR_IDLE: begin
        if (req_valid && req_ready) begin
          lat_write_next = req_write;
          lat_addr_next  = req_addr;
          lat_wdata_next = req_wdata;
          lat_be_next    = req_be;
          wait_cnt_next  = WAIT_W'(WAIT_CYCLES);
          state_next     = DMR_WAIT;
        end
      end

      DMR_WAIT: begin
        // The counter runs down to zero; the edge after it reads zero is
        // the response entry edge, giving WAIT_CYCLES+1 edges of latency.
        if (wait_cnt == '0) begin
          mem_en          = 1'b1;
          mem_we          = (lat_write && !acc_err) ? lat_be : '0;
          resp_valid_next = 1'b1;
          resp_err_next   = acc_err;
          rd_sel_next     = !lat_write && !acc_err;
          if (acc_err) begin
            err_count_next = sat_inc(err_count);
          end
          state_next      = DMR_RESP;
        end else begin
          wait_cnt_next = wait_cnt - 1'b1;
        end
      end

      DMR_RESP: begin
        if (resp_valid && resp_ready) begin
          resp_valid_next = 1'b0;
          resp_err_next   = 1'b0;
          rd_sel_next     = 1'b0;
          state_next      = DMR_IDLE;
        end
      end

      default: begin
        state_next = DMR_IDLE;
      end
    endcase

    req_ready_next = (state_next == DMR_IDLE);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the stimulus process pushes the
// expected response computed by a word-array reference model; a monitor
// process pops and compares whenever a response is presented.
module tb_data_mem_responder;

  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int unsigned cycle = 0;
  int n_resp = 0;
  bit hold = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  errc;
    int unsigned acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   active = 1'b0;

  // Reference model state.
  logic [31:0] model_mem [256];
  int          model_err = 0;

  data_mem_responder #(
    .MEM_WIDTH   (32),
    .MEM_SIZE    (256),
    .ADDR_WIDTH  (32),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  // Reference behaviour: memory of 256 words, bytes little-endian.
  function automatic exp_t model_access(input logic w, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    bit bad;
    bad = (a[1:0] != 2'b00) || (a >= 32'd1024);
    e.rdata = 32'h0;
    e.err   = bad;
    e.acc   = 0;
    if (bad) begin
      if (model_err < 255) model_err++;
    end else if (w) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) model_mem[a[9:2]][8*k +: 8] = d[8*k +: 8];
    end else begin
      e.rdata = model_mem[a[9:2]];
    end
    e.errc = 8'(model_err);
    return e;
  endfunction

  // Present a request and wait for it to be accepted; optionally score it.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit push);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = b;
    while (!req_ready) begin
      if (waited > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
    if (push) begin
      e = model_access(w, a, d, b);
      e.acc = cycle + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic wait_resp();
    int k;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  // Assert reset mid-cycle, check reset values, release and check req_ready rise.
  task automatic reset_now(input int cycles);
    reset = 1'b1;
    model_err = 0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("release_req_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("release_req_ready_high", 32'(req_ready), 32'd1);
  endtask

  // Monitor: pops one expectation per response, checks hold stability, drives resp_ready.
  initial begin : monitor
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
        resp_ready = 1'b0;
      end else if (resp_valid) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'(resp_valid), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            active = 1'b1;
            n_resp++;
            $display("resp %0d: rdata=0x%08h err=%0d err_count=%0d", n_resp, resp_rdata, resp_err, err_count);
            check("rdata", resp_rdata, cur.rdata);
            check("err", 32'(resp_err), 32'(cur.err));
            check("err_count", 32'(err_count), 32'(cur.errc));
            check("latency", 32'(cycle - cur.acc), 32'(WAITC + 1));
          end
        end else begin
          check("hold_rdata", resp_rdata, cur.rdata);
          check("hold_err", 32'(resp_err), 32'(cur.err));
        end
        check("busy_req_ready", 32'(req_ready), 32'd0);
        if (!hold && $urandom_range(3) != 0) begin
          resp_ready = 1'b1;
          active = 1'b0;
        end else begin
          resp_ready = 1'b0;
        end
      end else begin
        resp_ready = 1'($urandom);
      end
    end
  end

  // Stimulus.
  initial begin : stim
    logic [31:0] a;
    int r;

    // 1: reset held three cycles, then released.
    reset_now(3);

    // Known memory contents everywhere.
    for (int i = 0; i < 256; i++) issue(1'b1, 32'(i) << 2, $urandom, 4'hF, 1'b1);

    // 2: full store then load.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    // 3: single byte store, then load.
    issue(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    // be=0 store is a legal no-op.
    issue(1'b1, 32'h10, 32'h12345678, 4'h0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    // 4: misaligned and out-of-range loads, memory intact.
    issue(1'b0, 32'h12, 32'h0, 4'h0, 1'b1);
    issue(1'b0, 32'h400, 32'h0, 4'h0, 1'b1);
    issue(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    issue(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1);

    // 5: response held for five cycles while stray requests are offered.
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    hold = 1'b1;
    wait_resp();
    repeat (5) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_addr  = 32'h10;
      req_wdata = $urandom;
      req_be    = 4'hF;
      check("held_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    hold = 1'b0;

    // 6: reset during the wait phase of a store drops the store.
    issue(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0);
    #1;
    reset_now(2);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

    // Reset while a store response is pending: the store has committed.
    issue(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1'b1);
    hold = 1'b1;
    wait_resp();
    @(posedge clk);
    #2;
    hold = 1'b0;
    reset_now(2);
    issue(1'b0, 32'h24, 32'h0, 4'h0, 1'b1);

    // Randomised mix.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(9);
      if (r < 7)       a = 32'($urandom_range(255)) << 2;
      else if (r == 7) a = (32'($urandom_range(255)) << 2) | 32'($urandom_range(3, 1));
      else if (r == 8) a = $urandom | 32'h400;
      else             a = ($urandom_range(1) != 0) ? 32'h3FC : 32'h400;
      issue(1'($urandom), a, $urandom, 4'($urandom), 1'b1);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    // Error counter saturation.
    for (int i = 0; i < 260; i++) issue(1'b0, 32'h401 + 32'(i), 32'h0, 4'h0, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);

    // Drain outstanding responses.
    for (int k = 0; k < 300 && (exp_q.size() != 0 || active); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("final_err_count", 32'(err_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
